// File: rtl/mem_init_pkg.sv
// Shared types and sizes for the RAM initiator.
package mem_init_pkg;

    localparam int MEM_AW = 9;
    localparam int MEM_DW = 32;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE,
        ERR
    } mem_state_t;

endpackage

// File: rtl/mem_initiator.sv
// Initiator for the single-port 512 x 32 RAM: one load/store at a time,
// address/data set up a cycle before the strobe and held until after it.
//
// Handshake: cpu_req is sampled only while cpu_busy is low (IDLE). The
// request fields are captured on that edge; the caller sees exactly one
// cpu_ready pulse per accepted request (cpu_err qualifies it), after which
// the block spends one IDLE cycle before it can accept again.
module mem_initiator
    import mem_init_pkg::*;
#(
    parameter int WAIT_CYC   = 1,
    parameter int ADDR_CHECK = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_busy,
    output logic              cpu_ready,
    output logic              cpu_err,
    output logic [MEM_DW-1:0] cpu_rdata,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [MEM_DW-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [MEM_DW-1:0] mem_rdata,
    output mem_state_t        state_dbg
);

    // Counter value on the final strobe cycle.
    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYC - 1);

    mem_state_t        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [MEM_DW-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              cpu_ready_q, cpu_ready_d;
    logic              cpu_err_q, cpu_err_d;
    logic              cpu_busy_q, cpu_busy_d;
    logic [MEM_DW-1:0] cpu_rdata_q, cpu_rdata_d;

    // Next-state, datapath capture, and registered outputs decoded from the next state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rdata_d = cpu_rdata_q;

        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    we_d        = cpu_we;
                    mem_addr_d  = cpu_addr[MEM_AW-1:0];
                    mem_wdata_d = cpu_wdata;
                    if ((ADDR_CHECK != 0) && (|cpu_addr[31:MEM_AW])) begin
                        state_d = ERR;
                    end else begin
                        state_d = SETUP;
                    end
                end
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = '0;
            end
            ACCESS: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    // The read strobe is still high this cycle, so RAM data is valid.
                    if (!we_q) begin
                        cpu_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered copies of what the next state demands.
        mem_read_d  = (state_d == ACCESS) && !we_d;
        mem_write_d = (state_d == ACCESS) && we_d;
        cpu_ready_d = (state_d == DONE) || (state_d == ERR);
        cpu_err_d   = (state_d == ERR);
        cpu_busy_d  = (state_d != IDLE);
    end

    // State and output registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            cpu_ready_q <= 1'b0;
            cpu_err_q   <= 1'b0;
            cpu_busy_q  <= 1'b0;
            cpu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            cpu_ready_q <= cpu_ready_d;
            cpu_err_q   <= cpu_err_d;
            cpu_busy_q  <= cpu_busy_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

    assign cpu_busy  = cpu_busy_q;
    assign cpu_ready = cpu_ready_q;
    assign cpu_err   = cpu_err_q;
    assign cpu_rdata = cpu_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Directed bench for mem_initiator: a WAIT_CYC=1 and a WAIT_CYC=3 instance,
// each with a small combinational-read RAM model.
module tb_mem_initiator;
    import mem_init_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    // ---------------- shared request fields ----------------
    logic        req1 = 1'b0, req3 = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;

    // ---------------- DUT WAIT_CYC=1 ----------------
    logic        busy1, rdy1, err1, rd1, wr1;
    logic [31:0] rdata1, wdata1, mrdata1;
    logic [8:0]  addr1;
    mem_state_t  st1;
    logic [31:0] ram1 [512];

    mem_initiator #(.WAIT_CYC(1), .ADDR_CHECK(1)) dut1 (
        .clk(clk), .clr(clr), .cpu_req(req1), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_busy(busy1), .cpu_ready(rdy1), .cpu_err(err1), .cpu_rdata(rdata1),
        .mem_addr(addr1), .mem_wdata(wdata1), .mem_read(rd1), .mem_write(wr1),
        .mem_rdata(mrdata1), .state_dbg(st1)
    );
    assign mrdata1 = ram1[addr1];
    always @(posedge clk) if (wr1) ram1[addr1] <= wdata1;

    // ---------------- DUT WAIT_CYC=3 ----------------
    logic        busy3, rdy3, err3, rd3, wr3;
    logic [31:0] rdata3, wdata3, mrdata3;
    logic [8:0]  addr3;
    mem_state_t  st3;
    logic [31:0] ram3 [512];

    mem_initiator #(.WAIT_CYC(3), .ADDR_CHECK(1)) dut3 (
        .clk(clk), .clr(clr), .cpu_req(req3), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_busy(busy3), .cpu_ready(rdy3), .cpu_err(err3), .cpu_rdata(rdata3),
        .mem_addr(addr3), .mem_wdata(wdata3), .mem_read(rd3), .mem_write(wr3),
        .mem_rdata(mrdata3), .state_dbg(st3)
    );
    assign mrdata3 = ram3[addr3];
    always @(posedge clk) if (wr3) ram3[addr3] <= wdata3;

    // ---------------- observed-output select ----------------
    logic        sel = 1'b0;
    logic        o_busy, o_rdy, o_err, o_rd, o_wr;
    logic [31:0] o_rdata, o_wdata;
    logic [8:0]  o_addr;
    mem_state_t  o_st;
    always_comb begin
        o_busy  = sel ? busy3  : busy1;
        o_rdy   = sel ? rdy3   : rdy1;
        o_err   = sel ? err3   : err1;
        o_rd    = sel ? rd3    : rd1;
        o_wr    = sel ? wr3    : wr1;
        o_rdata = sel ? rdata3 : rdata1;
        o_wdata = sel ? wdata3 : wdata1;
        o_addr  = sel ? addr3  : addr1;
        o_st    = sel ? st3    : st1;
    end

    // ---------------- scoreboard counters ----------------
    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- driver: one transaction, checked cycle by cycle ----------------
    // Cycle 0 is the IDLE cycle in which the request is presented.
    task automatic run_txn(input logic s, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic exp_err,
                           input logic [31:0] exp_rd);
        int w;
        int last;
        logic e_strobe;
        w    = s ? 3 : 1;
        last = exp_err ? 1 : 2 + w;
        sel  = s;
        @(negedge clk);
        chk("idle_busy", {31'b0, o_busy}, 32'd0);
        cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        if (s) req3 = 1'b1; else req1 = 1'b1;
        @(negedge clk);
        req1 = 1'b0; req3 = 1'b0;
        for (int c = 1; c <= last + 1; c++) begin
            e_strobe = !exp_err && (c >= 2) && (c <= 1 + w);
            chk("mem_read",  {31'b0, o_rd}, {31'b0, e_strobe && !we});
            chk("mem_write", {31'b0, o_wr}, {31'b0, e_strobe && we});
            chk("cpu_ready", {31'b0, o_rdy}, {31'b0, c == last});
            chk("cpu_err",   {31'b0, o_err}, {31'b0, exp_err && (c == last)});
            chk("cpu_busy",  {31'b0, o_busy}, {31'b0, c <= last});
            if (!exp_err) begin
                chk("mem_addr",  {23'b0, o_addr}, {23'b0, addr[8:0]});
                chk("mem_wdata", o_wdata, wdata);
            end
            if (c >= last) chk("cpu_rdata", o_rdata, exp_rd);
            if (c <= last) @(negedge clk);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t vecs [9];

    initial begin
        // Store/load pairs against the WAIT_CYC=1 instance. exp_rd is what
        // cpu_rdata must show on the completion cycle.
        vecs[0] = '{1'b1, 32'h0000_0085, 32'h0000_000F, 1'b0, 32'h0000_0000};
        vecs[1] = '{1'b0, 32'h0000_0085, 32'h0000_0000, 1'b0, 32'h0000_000F};
        vecs[2] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_000F};
        vecs[3] = '{1'b0, 32'h0000_0200, 32'h0000_0000, 1'b1, 32'h0000_000F};
        vecs[4] = '{1'b0, 32'h0000_0010, 32'h1111_2222, 1'b0, 32'hDEAD_BEEF};
        vecs[5] = '{1'b1, 32'h0000_01FF, 32'hA5A5_A5A5, 1'b0, 32'hDEAD_BEEF};
        vecs[6] = '{1'b1, 32'h8000_0005, 32'h5555_5555, 1'b1, 32'hDEAD_BEEF};
        vecs[7] = '{1'b0, 32'h0000_01FF, 32'h0000_0000, 1'b0, 32'hA5A5_A5A5};
        vecs[8] = '{1'b0, 32'h0000_0005, 32'h0000_0000, 1'b0, 32'h0000_0000};

        for (int i = 0; i < 512; i++) begin
            ram1[i] = 32'h0;
            ram3[i] = 32'h0;
        end
        ram3[9'h044] = 32'hFFFF_FFF0;

        // Reset state, checked while clr is still low.
        repeat (2) @(negedge clk);
        sel = 1'b0;
        chk("rst_state",  {29'b0, o_st}, {29'b0, IDLE});
        chk("rst_busy",   {31'b0, o_busy}, 32'd0);
        chk("rst_ready",  {31'b0, o_rdy}, 32'd0);
        chk("rst_err",    {31'b0, o_err}, 32'd0);
        chk("rst_strobe", {30'b0, o_rd, o_wr}, 32'd0);
        chk("rst_addr",   {23'b0, o_addr}, 32'd0);
        chk("rst_wdata",  o_wdata, 32'd0);
        chk("rst_rdata",  o_rdata, 32'd0);
        clr = 1'b1;

        // Table-driven single transactions, WAIT_CYC=1.
        for (int i = 0; i < 9; i++) begin
            run_txn(1'b0, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                    vecs[i].exp_err, vecs[i].exp_rd);
        end

        // WAIT_CYC=3 load: strobe cycles 2..4, ready in cycle 5.
        run_txn(1'b1, 1'b0, 32'h0000_0044, 32'h0, 1'b0, 32'hFFFF_FFF0);

        // cpu_req held high across two loads: second acceptance in cycle 4.
        sel = 1'b0;
        @(negedge clk);
        cpu_we = 1'b0; cpu_addr = 32'h0000_0085; cpu_wdata = 32'h0;
        req1 = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            if (c == 5) req1 = 1'b0;
            chk("hold_busy",  {31'b0, o_busy},
                {31'b0, (c >= 1 && c <= 3) || (c >= 5 && c <= 7)});
            chk("hold_read",  {31'b0, o_rd}, {31'b0, c == 2 || c == 6});
            chk("hold_write", {31'b0, o_wr}, 32'd0);
            chk("hold_ready", {31'b0, o_rdy}, {31'b0, c == 3 || c == 7});
            if (c == 3 || c == 7) chk("hold_rdata", o_rdata, 32'h0000_000F);
            @(negedge clk);
        end

        // Reset pulled in cycle 2 of a store.
        cpu_we = 1'b1; cpu_addr = 32'h0000_0033; cpu_wdata = 32'h1234_5678;
        req1 = 1'b1;
        @(negedge clk);
        req1 = 1'b0;
        @(negedge clk);
        chk("mid_write_before", {31'b0, o_wr}, 32'd1);
        clr = 1'b0;
        #1;
        chk("mid_write_after", {31'b0, o_wr}, 32'd0);
        chk("mid_busy",   {31'b0, o_busy}, 32'd0);
        chk("mid_addr",   {23'b0, o_addr}, 32'd0);
        chk("mid_wdata",  o_wdata, 32'd0);
        chk("mid_rdata",  o_rdata, 32'd0);
        chk("mid_state",  {29'b0, o_st}, {29'b0, IDLE});
        @(negedge clk);
        clr = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("post_rst_ready", {31'b0, o_rdy}, 32'd0);
            chk("post_rst_busy",  {31'b0, o_busy}, 32'd0);
            chk("post_rst_state", {29'b0, o_st}, {29'b0, IDLE});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // Strobes must never overlap on either instance.
    always @(negedge clk) begin
        if ((rd1 && wr1) || (rd3 && wr3)) begin
            n_fail++;
            $display("FAIL strobe_overlap @%0t: rd1=%b wr1=%b rd3=%b wr3=%b required no overlap",
                     $time, rd1, wr1, rd3, wr3);
        end
    end

endmodule
